probatina_ctrl_s_axi: RTL and testbench

AXI4-Lite slave register file directly upstream of the probatina_example kernel core. It turns host register accesses into the ap_start level and the 64-bit axi00_ptr0 argument, and captures ap_done/ap_idle/ap_ready status from the core. It also generates the host interrupt. Single clock domain (ap_clk), no CDC.

---
 rtl/probatina_ctrl_pkg.sv | 36 +++
 rtl/probatina_ctrl_s_axi_if.sv | 33 +++
 rtl/probatina_ctrl_s_axi.sv | 199 +++++++++++++++++++
 tb/tb_probatina_ctrl_s_axi.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/probatina_ctrl_pkg.sv
// Shared definitions for the probatina AXI4-Lite control slave: register
// offsets, CTRL bit positions, FSM state types and the byte-strobe merge helper.
package probatina_ctrl_pkg;

    localparam int unsigned REG_ADDR_BITS = 6;
    typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;

    localparam reg_addr_t ADDR_CTRL    = 6'h00;
    localparam reg_addr_t ADDR_GIE     = 6'h04;
    localparam reg_addr_t ADDR_IER     = 6'h08;
    localparam reg_addr_t ADDR_ISR     = 6'h0C;
    localparam reg_addr_t ADDR_PTR0_LO = 6'h10;
    localparam reg_addr_t ADDR_PTR0_HI = 6'h14;

    localparam int unsigned CTRL_AP_START     = 0;
    localparam int unsigned CTRL_AP_DONE      = 1;
    localparam int unsigned CTRL_AP_IDLE      = 2;
    localparam int unsigned CTRL_AP_READY     = 3;
    localparam int unsigned CTRL_AUTO_RESTART = 7;

    typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wr_state_t;
    typedef enum logic       {RDIDLE, RDDATA}         rd_state_t;

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/probatina_ctrl_s_axi_if.sv
// AXI4-Lite bus bundle for the probatina control slave; slave modport for the
// register file, master modport for whatever drives it.
interface probatina_ctrl_s_axi_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/probatina_ctrl_s_axi.sv
// AXI4-Lite register file driving ap_start/axi00_ptr0 of the probatina core.
// Define PROBATINA_CTRL_IRQ_EN to build GIE/IER/ISR and the interrupt output.
module probatina_ctrl_s_axi
    import probatina_ctrl_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                  ap_clk,
    input  logic                  areset,
    probatina_ctrl_s_axi_if.slave s_axi,
    output logic                  ap_start,
    input  logic                  ap_done,
    input  logic                  ap_idle,
    input  logic                  ap_ready,
    output logic [63:0]           axi00_ptr0,
    output logic                  interrupt
);

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;
    logic      awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic      arready_q, arready_d, rvalid_q, rvalid_d;
    reg_addr_t waddr_q, waddr_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [31:0] rd_mux;

    logic        ap_start_q, ap_start_d;
    logic        auto_restart_q, auto_restart_d;
    logic        done_latch_q, done_latch_d;
    logic [31:0] ptr_lo_q, ptr_lo_d, ptr_hi_q, ptr_hi_d;

    logic aw_hs, w_hs, ar_hs, ctrl_rd;

    wire unused_addr_hi = &{1'b0, s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:REG_ADDR_BITS],
                                  s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:REG_ADDR_BITS]};

    assign aw_hs   = s_axi.awvalid & awready_q;
    assign w_hs    = s_axi.wvalid  & wready_q;
    assign ar_hs   = s_axi.arvalid & arready_q;
    assign ctrl_rd = ar_hs && (s_axi.araddr[REG_ADDR_BITS-1:0] == ADDR_CTRL);

    // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_state_d = wr_state_q;
        waddr_d    = waddr_q;
        case (wr_state_q)
            WRIDLE:  if (aw_hs) begin
                         waddr_d    = s_axi.awaddr[REG_ADDR_BITS-1:0];
                         wr_state_d = WRDATA;
                     end
            WRDATA:  if (w_hs) wr_state_d = WRRESP;
            WRRESP:  if (s_axi.bready) wr_state_d = WRIDLE;
            default: wr_state_d = WRIDLE;
        endcase
        awready_d = (wr_state_d == WRIDLE);
        wready_d  = (wr_state_d == WRDATA);
        bvalid_d  = (wr_state_d == WRRESP);

        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            RDIDLE:  if (ar_hs) begin
                         rdata_d    = rd_mux;
                         rd_state_d = RDDATA;
                     end
            RDDATA:  if (s_axi.rready) rd_state_d = RDIDLE;
            default: rd_state_d = RDIDLE;
        endcase
        arready_d = (rd_state_d == RDIDLE);
        rvalid_d  = (rd_state_d == RDDATA);
    end

    always_comb begin
        ap_start_d     = ap_start_q;
        auto_restart_d = auto_restart_q;
        done_latch_d   = done_latch_q;
        ptr_lo_d       = ptr_lo_q;
        ptr_hi_d       = ptr_hi_q;

        if (ap_ready && !auto_restart_q) ap_start_d = 1'b0;
        if (w_hs && waddr_q == ADDR_CTRL && s_axi.wstrb[0]) begin
            auto_restart_d = s_axi.wdata[CTRL_AUTO_RESTART];
            if (s_axi.wdata[CTRL_AP_START]) ap_start_d = 1'b1;
        end

        // A done pulse coinciding with the clearing read keeps the latch set.
        if (ctrl_rd) done_latch_d = 1'b0;
        if (ap_done) done_latch_d = 1'b1;

        if (w_hs && waddr_q == ADDR_PTR0_LO) ptr_lo_d = apply_wstrb(ptr_lo_q, s_axi.wdata, s_axi.wstrb);
        if (w_hs && waddr_q == ADDR_PTR0_HI) ptr_hi_d = apply_wstrb(ptr_hi_q, s_axi.wdata, s_axi.wstrb);
    end

`ifdef PROBATINA_CTRL_IRQ_EN
    logic       gie_q, gie_d, interrupt_q, interrupt_d;
    logic [1:0] ier_q, ier_d, isr_q, isr_d, irq_evt;

    always_comb begin
        gie_d = gie_q;
        ier_d = ier_q;
        isr_d = isr_q;
        if (w_hs && waddr_q == ADDR_GIE && s_axi.wstrb[0]) gie_d = s_axi.wdata[0];
        if (w_hs && waddr_q == ADDR_IER && s_axi.wstrb[0]) ier_d = s_axi.wdata[1:0];
        irq_evt = {ap_ready, ap_done} & ier_q;
        for (int n = 0; n < 2; n++) begin
            if (w_hs && waddr_q == ADDR_ISR && s_axi.wstrb[0] && s_axi.wdata[n]) isr_d[n] = ~isr_q[n];
            if (irq_evt[n]) isr_d[n] = 1'b1;
        end
        interrupt_d = gie_q & (|isr_q);
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            gie_q       <= 1'b0;
            ier_q       <= '0;
            isr_q       <= '0;
            interrupt_q <= 1'b0;
        end else begin
            gie_q       <= gie_d;
            ier_q       <= ier_d;
            isr_q       <= isr_d;
            interrupt_q <= interrupt_d;
        end
    end

    assign interrupt = interrupt_q;
`else
    assign interrupt = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (s_axi.araddr[REG_ADDR_BITS-1:0])
            ADDR_CTRL: begin
                rd_mux[CTRL_AP_START]     = ap_start_q;
                rd_mux[CTRL_AP_DONE]      = done_latch_q;
                rd_mux[CTRL_AP_IDLE]      = ap_idle;
                rd_mux[CTRL_AP_READY]     = ap_ready;
                rd_mux[CTRL_AUTO_RESTART] = auto_restart_q;
            end
`ifdef PROBATINA_CTRL_IRQ_EN
            ADDR_GIE:     rd_mux[0]   = gie_q;
            ADDR_IER:     rd_mux[1:0] = ier_q;
            ADDR_ISR:     rd_mux[1:0] = isr_q;
`endif
            ADDR_PTR0_LO: rd_mux = ptr_lo_q;
            ADDR_PTR0_HI: rd_mux = ptr_hi_q;
            default:      rd_mux = '0;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_state_q     <= WRIDLE;
            rd_state_q     <= RDIDLE;
            awready_q      <= 1'b0;
            wready_q       <= 1'b0;
            bvalid_q       <= 1'b0;
            arready_q      <= 1'b0;
            rvalid_q       <= 1'b0;
            waddr_q        <= '0;
            rdata_q        <= '0;
            ap_start_q     <= 1'b0;
            auto_restart_q <= 1'b0;
            done_latch_q   <= 1'b0;
            ptr_lo_q       <= '0;
            ptr_hi_q       <= '0;
        end else begin
            wr_state_q     <= wr_state_d;
            rd_state_q     <= rd_state_d;
            awready_q      <= awready_d;
            wready_q       <= wready_d;
            bvalid_q       <= bvalid_d;
            arready_q      <= arready_d;
            rvalid_q       <= rvalid_d;
            waddr_q        <= waddr_d;
            rdata_q        <= rdata_d;
            ap_start_q     <= ap_start_d;
            auto_restart_q <= auto_restart_d;
            done_latch_q   <= done_latch_d;
            ptr_lo_q       <= ptr_lo_d;
            ptr_hi_q       <= ptr_hi_d;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;
    assign ap_start      = ap_start_q;
    assign axi00_ptr0    = {ptr_hi_q, ptr_lo_q};

endmodule

// File: tb/tb_probatina_ctrl_s_axi.sv
// Directed bench for probatina_ctrl_s_axi: register-map vector table plus
// hand sequences for ap_start, done latch, interrupt and read back-pressure.
module tb_probatina_ctrl_s_axi;

`ifdef PROBATINA_CTRL_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif
    localparam int BUDGET = 20;

    logic        ap_clk = 1'b0;
    logic        areset;
    logic        ap_start, ap_done, ap_idle, ap_ready, interrupt;
    logic [63:0] axi00_ptr0;

    probatina_ctrl_s_axi_if #(.ADDR_WIDTH(12)) bus ();

    probatina_ctrl_s_axi #(.C_S_AXI_ADDR_WIDTH(12), .C_S_AXI_DATA_WIDTH(32)) dut (
        .ap_clk     (ap_clk),
        .areset     (areset),
        .s_axi      (bus),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .axi00_ptr0 (axi00_ptr0),
        .interrupt  (interrupt)
    );

    always #5 ap_clk = ~ap_clk;

    int   checks = 0;
    int   errors = 0;
    logic start_after_w;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake wait expired after %0d cycles", name, BUDGET);
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge ap_clk);
        bus.awvalid = 1'b1;
        bus.awaddr  = addr;
        n = 0;
        while (!bus.awready && n < BUDGET) begin @(negedge ap_clk); n++; end
        if (n == BUDGET) timed_out("awready");
        @(negedge ap_clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        n = 0;
        while (!bus.wready && n < BUDGET) begin @(negedge ap_clk); n++; end
        if (n == BUDGET) timed_out("wready");
        @(negedge ap_clk);
        bus.wvalid    = 1'b0;
        start_after_w = ap_start;
        n = 0;
        while (!bus.bvalid && n < BUDGET) begin @(negedge ap_clk); n++; end
        if (n == BUDGET) timed_out("bvalid");
        check("bresp", bus.bresp, 2'b00);
        bus.bready = 1'b1;
        @(negedge ap_clk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] addr, input bit done_at_ar, output logic [31:0] data);
        int n;
        @(negedge ap_clk);
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        n = 0;
        while (!bus.arready && n < BUDGET) begin @(negedge ap_clk); n++; end
        if (n == BUDGET) timed_out("arready");
        if (done_at_ar) ap_done = 1'b1;
        @(negedge ap_clk);
        bus.arvalid = 1'b0;
        ap_done     = 1'b0;
        n = 0;
        while (!bus.rvalid && n < BUDGET) begin @(negedge ap_clk); n++; end
        if (n == BUDGET) timed_out("rvalid");
        data       = bus.rdata;
        bus.rready = 1'b1;
        @(negedge ap_clk);
        bus.rready = 1'b0;
    endtask

    task automatic pulse_ready();
        @(negedge ap_clk);
        ap_ready = 1'b1;
        @(negedge ap_clk);
        ap_ready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic [63:0] exp_ptr;
        string       name;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;

        vecs[0]  = '{1'b0, 12'h000, 32'h0,        4'h0, 32'h0000_0004, 64'h0,                   "ctrl_reset"};
        vecs[1]  = '{1'b1, 12'h010, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF, "ptr_lo_full"};
        vecs[2]  = '{1'b1, 12'h014, 32'h0000_0001, 4'hF, 32'h0000_0001, 64'h0000_0001_DEAD_BEEF, "ptr_hi_full"};
        vecs[3]  = '{1'b1, 12'h010, 32'h0000_00FF, 4'h1, 32'hDEAD_BEFF, 64'h0000_0001_DEAD_BEFF, "ptr_lo_byte0"};
        vecs[4]  = '{1'b1, 12'h014, 32'hAABB_CCDD, 4'h6, 32'h00BB_CC01, 64'h00BB_CC01_DEAD_BEFF, "ptr_hi_mid"};
        vecs[5]  = '{1'b1, 12'h014, 32'h0000_0001, 4'hF, 32'h0000_0001, 64'h0000_0001_DEAD_BEFF, "ptr_hi_restore"};
        vecs[6]  = '{1'b1, 12'h020, 32'h1234_5678, 4'hF, 32'h0000_0000, 64'h0000_0001_DEAD_BEFF, "unmapped"};
        vecs[7]  = '{1'b1, 12'h004, 32'h0000_0001, 4'hF, IRQ ? 32'h1 : 32'h0, 64'h0000_0001_DEAD_BEFF, "gie"};
        vecs[8]  = '{1'b1, 12'h008, 32'h0000_0003, 4'h0, 32'h0000_0000, 64'h0000_0001_DEAD_BEFF, "ier_no_strb"};
        vecs[9]  = '{1'b0, 12'h050, 32'h0,        4'h0, 32'hDEAD_BEFF, 64'h0000_0001_DEAD_BEFF, "alias_lo"};
        vecs[10] = '{1'b0, 12'h03C, 32'h0,        4'h0, 32'h0000_0000, 64'h0000_0001_DEAD_BEFF, "unmapped_top"};

        areset   = 1'b1;
        ap_done  = 1'b0;
        ap_idle  = 1'b1;
        ap_ready = 1'b0;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.bready  = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;
        repeat (3) @(negedge ap_clk);
        check("rst_awready", bus.awready, 1'b0);
        areset = 1'b0;
        @(negedge ap_clk);
        check("rst_ap_start",  ap_start,    1'b0);
        check("rst_interrupt", interrupt,   1'b0);
        check("rst_ptr",       axi00_ptr0,  64'h0);
        check("rst_awready1",  bus.awready, 1'b1);
        check("rst_arready1",  bus.arready, 1'b1);
        check("rst_bvalid",    bus.bvalid,  1'b0);
        check("rst_rvalid",    bus.rvalid,  1'b0);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            axi_read(vecs[i].addr, 1'b0, rd);
            check({vecs[i].name, "_rd"}, rd, vecs[i].exp_rd);
            check({vecs[i].name, "_ptr"}, axi00_ptr0, vecs[i].exp_ptr);
        end

        // ap_start set by write-1, held, cleared by ap_ready
        axi_write(12'h000, 32'h1, 4'h1);
        check("start_next_cycle", start_after_w, 1'b1);
        repeat (3) @(negedge ap_clk);
        check("start_held", ap_start, 1'b1);
        pulse_ready();
        check("start_cleared", ap_start, 1'b0);

        // done latch: clear-on-read
        @(negedge ap_clk); ap_done = 1'b1;
        @(negedge ap_clk); ap_done = 1'b0;
        axi_read(12'h000, 1'b0, rd);
        check("done_first_read", rd, 32'h6);
        axi_read(12'h000, 1'b0, rd);
        check("done_second_read", rd, 32'h4);

        // done pulse in the ar handshake cycle: set wins, data is pre-event
        axi_read(12'h000, 1'b1, rd);
        check("done_race_data", rd, 32'h4);
        axi_read(12'h000, 1'b0, rd);
        check("done_race_latched", rd, 32'h6);
        axi_read(12'h000, 1'b0, rd);
        check("done_race_cleared", rd, 32'h4);

        // auto_restart keeps ap_start through ap_ready
        axi_write(12'h000, 32'h81, 4'h1);
        check("ar_start_set", start_after_w, 1'b1);
        axi_read(12'h000, 1'b0, rd);
        check("ar_ctrl_read", rd, 32'h85);
        pulse_ready();
        check("ar_start_kept", ap_start, 1'b1);
        axi_write(12'h000, 32'h00, 4'h1);
        check("write0_no_clear", ap_start, 1'b1);
        axi_read(12'h000, 1'b0, rd);
        check("ar_off_ctrl", rd, 32'h05);
        pulse_ready();
        check("ar_off_cleared", ap_start, 1'b0);

`ifdef PROBATINA_CTRL_IRQ_EN
        axi_write(12'h004, 32'h1, 4'h1);
        axi_write(12'h008, 32'h1, 4'h1);
        @(negedge ap_clk); ap_done = 1'b1;
        @(negedge ap_clk); ap_done = 1'b0;
        check("irq_one_cycle", interrupt, 1'b0);
        @(negedge ap_clk);
        check("irq_two_cycles", interrupt, 1'b1);
        axi_read(12'h00C, 1'b0, rd);
        check("isr_done", rd, 32'h1);
        axi_write(12'h00C, 32'h1, 4'h1);
        check("irq_cleared", interrupt, 1'b0);
        axi_read(12'h00C, 1'b0, rd);
        check("isr_toggled_off", rd, 32'h0);
        axi_write(12'h00C, 32'h2, 4'h1);
        check("irq_toggle_on", interrupt, 1'b1);
        axi_read(12'h00C, 1'b0, rd);
        check("isr_toggled_on", rd, 32'h2);
        axi_write(12'h00C, 32'h2, 4'h1);
        check("irq_toggle_off", interrupt, 1'b0);
`else
        axi_write(12'h008, 32'h3, 4'hF);
        axi_write(12'h00C, 32'h3, 4'hF);
        @(negedge ap_clk); ap_done = 1'b1;
        @(negedge ap_clk); ap_done = 1'b0;
        repeat (2) @(negedge ap_clk);
        check("irq_absent", interrupt, 1'b0);
        axi_read(12'h00C, 1'b0, rd);
        check("isr_absent", rd, 32'h0);
`endif

        // read back-pressure: rdata held while rready is low
        @(negedge ap_clk);
        bus.arvalid = 1'b1;
        bus.araddr  = 12'h010;
        check("hold_arready", bus.arready, 1'b1);
        @(negedge ap_clk);
        bus.arvalid = 1'b0;
        bus.araddr  = 12'h014;
        check("hold_latency", bus.rvalid, 1'b1);
        check("hold_rresp", bus.rresp, 2'b00);
        for (int c = 0; c < 5; c++) begin
            check("hold_rvalid", bus.rvalid, 1'b1);
            check("hold_rdata", bus.rdata, 32'hDEAD_BEFF);
            @(negedge ap_clk);
        end
        bus.rready = 1'b1;
        @(negedge ap_clk);
        bus.rready = 1'b0;
        check("hold_released", bus.rvalid, 1'b0);

        // reset mid-write drops the transaction and clears the registers
        @(negedge ap_clk);
        bus.awvalid = 1'b1;
        bus.awaddr  = 12'h010;
        @(negedge ap_clk);
        bus.awvalid = 1'b0;
        check("midrst_wready", bus.wready, 1'b1);
        areset = 1'b1;
        @(negedge ap_clk);
        areset = 1'b0;
        check("midrst_wready_gone", bus.wready, 1'b0);
        check("midrst_bvalid", bus.bvalid, 1'b0);
        check("midrst_ptr", axi00_ptr0, 64'h0);
        @(negedge ap_clk);
        check("midrst_awready", bus.awready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
